controlador_subtracao_matrizes: RTL and testbench

Command-driven sequencer for the 5x5 signed 8-bit matrix subtraction datapath in the coprocessor. It performs these steps:
- loads operand matrices A and B one column (5 elements, 40 bits) at a time;
- launches the combinational subtractor and captures A-B into a result register;
- returns result columns on request.
Every accepted command produces exactly one response over a valid/ready handshake.

---
 rtl/controlador_subtracao_matrizes_pkg.sv | 28 ++
 rtl/controlador_subtracao_matrizes_subtrator.sv | 20 ++
 rtl/controlador_subtracao_matrizes.sv | 133 +++++++++++++
 tb/tb_controlador_subtracao_matrizes.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/controlador_subtracao_matrizes_pkg.sv
// Shared coprocessor definitions: matrix geometry, command opcodes,
// sequencer states and the column bit-offset helper.
package pacote_coprocessador;

  localparam int N           = 5;
  localparam int LARGURA     = 8;
  localparam int MATRIZ_BITS = N * N * LARGURA;
  localparam int COLUNA_BITS = N * LARGURA;

  typedef enum logic [1:0] {
    CARREGA_A    = 2'd0,
    CARREGA_B    = 2'd1,
    EXECUTA      = 2'd2,
    LE_RESULTADO = 2'd3
  } cmd_op_t;

  typedef logic [1:0] estado_t;
  localparam estado_t OCIOSO      = 2'd0;
  localparam estado_t EXECUTANDO  = 2'd1;
  localparam estado_t RESPONDENDO = 2'd2;

  // Bit position of the first element of a column inside a 200-bit matrix.
  // Only meaningful for columns 0..4 (callers check the index first).
  function automatic logic [7:0] offset_coluna(input logic [2:0] coluna);
    return 8'(coluna) * 8'(COLUNA_BITS);
  endfunction

endpackage

// File: rtl/controlador_subtracao_matrizes_subtrator.sv
// Combinational element-wise subtractor for N x N matrices of signed
// LARGURA-bit elements. Results wrap modulo 2^LARGURA (no saturation).
module subtrator_matrizes #(
  parameter int N       = 5,
  parameter int LARGURA = 8
) (
  input  logic [N*N*LARGURA-1:0] a_i,
  input  logic [N*N*LARGURA-1:0] b_i,
  output logic [N*N*LARGURA-1:0] sub_o
);

  for (genvar e = 0; e < N * N; e++) begin : g_elem
    logic signed [LARGURA-1:0] a_e;
    logic signed [LARGURA-1:0] b_e;
    assign a_e = a_i[e*LARGURA +: LARGURA];
    assign b_e = b_i[e*LARGURA +: LARGURA];
    assign sub_o[e*LARGURA +: LARGURA] = a_e - b_e;
  end

endmodule

// File: rtl/controlador_subtracao_matrizes.sv
// Command sequencer for the 5x5 matrix subtraction coprocessor: loads
// operand columns, captures A-B on EXECUTA and serves result columns.
// Each accepted command yields exactly one response on resp_*.
module controlador_subtracao_matrizes
  import pacote_coprocessador::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [2:0]             cmd_coluna,
  input  logic [COLUNA_BITS-1:0] cmd_dados,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [COLUNA_BITS-1:0] resp_dados,
  output logic                   resp_erro,
  output logic                   resultado_valido
);

  estado_t                  estado_q, estado_d;
  logic [MATRIZ_BITS-1:0]   matriz_a_q, matriz_a_d;
  logic [MATRIZ_BITS-1:0]   matriz_b_q, matriz_b_d;
  logic [MATRIZ_BITS-1:0]   matriz_res_q, matriz_res_d;
  logic                     valido_q, valido_d;
  logic [COLUNA_BITS-1:0]   resp_dados_q, resp_dados_d;
  logic                     resp_erro_q, resp_erro_d;
  logic [MATRIZ_BITS-1:0]   sub_out;
  logic                     coluna_ok;

  subtrator_matrizes #(
    .N       (N),
    .LARGURA (LARGURA)
  ) u_subtrator (
    .a_i   (matriz_a_q),
    .b_i   (matriz_b_q),
    .sub_o (sub_out)
  );

  assign coluna_ok        = (cmd_coluna <= 3'd4);
  assign cmd_ready        = (estado_q == OCIOSO);
  assign resp_valid       = (estado_q == RESPONDENDO);
  assign resp_dados       = resp_dados_q;
  assign resp_erro        = resp_erro_q;
  assign resultado_valido = valido_q;

  // Next-state and datapath update decisions for the command sequencer.
  always_comb begin
    estado_d     = estado_q;
    matriz_a_d   = matriz_a_q;
    matriz_b_d   = matriz_b_q;
    matriz_res_d = matriz_res_q;
    valido_d     = valido_q;
    resp_dados_d = resp_dados_q;
    resp_erro_d  = resp_erro_q;

    case (estado_q)
      OCIOSO: begin
        if (cmd_valid) begin
          case (cmd_op_t'(cmd_op))
            CARREGA_A, CARREGA_B: begin
              estado_d     = RESPONDENDO;
              resp_dados_d = '0;
              if (coluna_ok) begin
                resp_erro_d = 1'b0;
                // Any operand change makes the captured result stale.
                valido_d    = 1'b0;
                if (cmd_op_t'(cmd_op) == CARREGA_A)
                  matriz_a_d[offset_coluna(cmd_coluna) +: COLUNA_BITS] = cmd_dados;
                else
                  matriz_b_d[offset_coluna(cmd_coluna) +: COLUNA_BITS] = cmd_dados;
              end else begin
                resp_erro_d = 1'b1;
              end
            end
            EXECUTA: begin
              estado_d = EXECUTANDO;
            end
            LE_RESULTADO: begin
              estado_d = RESPONDENDO;
              if (coluna_ok && valido_q) begin
                resp_dados_d = matriz_res_q[offset_coluna(cmd_coluna) +: COLUNA_BITS];
                resp_erro_d  = 1'b0;
              end else begin
                resp_dados_d = '0;
                resp_erro_d  = 1'b1;
              end
            end
          endcase
        end
      end
      EXECUTANDO: begin
        matriz_res_d = sub_out;
        valido_d     = 1'b1;
        resp_dados_d = '0;
        resp_erro_d  = 1'b0;
        estado_d     = RESPONDENDO;
      end
      RESPONDENDO: begin
        if (resp_ready) begin
          estado_d     = OCIOSO;
          resp_dados_d = '0;
          resp_erro_d  = 1'b0;
        end
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // State and storage registers; reset clears matrices and abandons any response.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      matriz_a_q   <= '0;
      matriz_b_q   <= '0;
      matriz_res_q <= '0;
      valido_q     <= 1'b0;
      resp_dados_q <= '0;
      resp_erro_q  <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      matriz_a_q   <= matriz_a_d;
      matriz_b_q   <= matriz_b_d;
      matriz_res_q <= matriz_res_d;
      valido_q     <= valido_d;
      resp_dados_q <= resp_dados_d;
      resp_erro_q  <= resp_erro_d;
    end
  end

endmodule

// File: tb/tb_controlador_subtracao_matrizes.sv
// Self-checking bench for controlador_subtracao_matrizes: a byte-array
// model of the three matrices predicts every response, a monitor checks
// responses and hold stability, and directed tests pin literal values.
module tb_controlador_subtracao_matrizes;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [2:0]  cmd_coluna;
  logic [39:0] cmd_dados;
  logic        resp_valid;
  logic        resp_ready;
  logic [39:0] resp_dados;
  logic        resp_erro;
  logic        resultado_valido;

  controlador_subtracao_matrizes dut (
    .clk              (clk),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_coluna       (cmd_coluna),
    .cmd_dados        (cmd_dados),
    .resp_valid       (resp_valid),
    .resp_ready       (resp_ready),
    .resp_dados       (resp_dados),
    .resp_erro        (resp_erro),
    .resultado_valido (resultado_valido)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] ma   [5][5];
  logic [7:0] mb   [5][5];
  logic [7:0] mres [5][5];
  logic       mvalid;

  typedef struct {
    logic [39:0] d;
    logic        e;
    logic        v;
  } exp_t;
  exp_t expq[$];

  function automatic void model_clear();
    for (int c = 0; c < 5; c++)
      for (int l = 0; l < 5; l++) begin
        ma[c][l] = 8'h00; mb[c][l] = 8'h00; mres[c][l] = 8'h00;
      end
    mvalid = 1'b0;
  endfunction

  function automatic logic [39:0] res_col(input int c);
    logic [39:0] r;
    for (int l = 0; l < 5; l++) r[8*l +: 8] = mres[c][l];
    return r;
  endfunction

  function automatic exp_t model_cmd(input logic [1:0] op, input int col, input logic [39:0] data);
    exp_t x;
    x.d = '0; x.e = 1'b0; x.v = mvalid;
    case (op)
      2'd0, 2'd1: begin
        if (col <= 4) begin
          for (int l = 0; l < 5; l++)
            if (op == 2'd0) ma[col][l] = data[8*l +: 8];
            else            mb[col][l] = data[8*l +: 8];
          mvalid = 1'b0;
        end else begin
          x.e = 1'b1;
        end
      end
      2'd2: begin
        for (int c = 0; c < 5; c++)
          for (int l = 0; l < 5; l++) mres[c][l] = ma[c][l] - mb[c][l];
        mvalid = 1'b1;
      end
      default: begin
        if (col <= 4 && mvalid) x.d = res_col(col);
        else                    x.e = 1'b1;
      end
    endcase
    x.v = mvalid;
    return x;
  endfunction

  // ---------------- response monitor ----------------
  logic        pv = 1'b0;
  logic [39:0] pd;
  logic        pe;

  always begin
    @(negedge clk);
    #1;
    if (resp_valid && !reset) begin
      chk("cmd_ready low while responding", cmd_ready, 0);
      if (pv) begin
        chk("resp_dados held", resp_dados, pd);
        chk("resp_erro held", resp_erro, pe);
      end
      if (resp_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected response: got %0h expected none", resp_dados);
        end else begin
          exp_t x;
          x = expq.pop_front();
          chk("resp_dados vs model", resp_dados, x.d);
          chk("resp_erro vs model", resp_erro, x.e);
          chk("resultado_valido vs model", resultado_valido, x.v);
        end
        pv = 1'b0;
      end else begin
        pv = 1'b1; pd = resp_dados; pe = resp_erro;
      end
    end else begin
      pv = 1'b0;
    end
  end

  // ---------------- command driver ----------------
  task automatic do_cmd(input logic [1:0] op, input logic [2:0] col, input logic [39:0] data,
                        input int hold, output logic [39:0] got_d, output logic got_e);
    exp_t x;
    int   lat;
    bit   ok;
    got_d = '0; got_e = 1'b0;
    @(negedge clk);
    cmd_op = op; cmd_coluna = col; cmd_dados = data; cmd_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (cmd_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL cmd_ready timeout: got 0 expected 1");
      cmd_valid = 1'b0;
      return;
    end
    x = model_cmd(op, int'(col), data);
    expq.push_back(x);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (resp_valid) ok = 1'b1;
      else begin @(negedge clk); lat++; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL resp_valid timeout: got 0 expected 1");
      expq.delete();
      return;
    end
    chk("response latency", 64'(lat), (op == 2'd2) ? 64'd2 : 64'd1);
    got_d = resp_dados; got_e = resp_erro;
    for (int i = 0; i < hold; i++) begin
      chk("cmd_ready low during hold", cmd_ready, 0);
      chk("resp_valid held", resp_valid, 1);
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    chk("cmd_ready after resp handshake", cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    logic [39:0] d;
    logic        e;

    reset = 1'b1; cmd_valid = 1'b0; resp_ready = 1'b0;
    cmd_op = '0; cmd_coluna = '0; cmd_dados = '0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset resp_valid", resp_valid, 0);
    chk("reset resp_dados", resp_dados, 0);
    chk("reset resp_erro", resp_erro, 0);
    chk("reset resultado_valido", resultado_valido, 0);

    // read before any EXECUTA
    do_cmd(2'd3, 3'd0, '0, 0, d, e);
    chk("early read erro", e, 1);
    chk("early read dados", d, 40'h0);

    // basic 5 - 3
    for (int c = 0; c < 5; c++) do_cmd(2'd0, 3'(c), 40'h0505050505, 0, d, e);
    for (int c = 0; c < 5; c++) do_cmd(2'd1, 3'(c), 40'h0303030303, 0, d, e);
    do_cmd(2'd2, 3'd0, '0, 0, d, e);
    chk("execute valido", resultado_valido, 1);
    for (int c = 0; c < 5; c++) begin
      do_cmd(2'd3, 3'(c), '0, 0, d, e);
      chk("t1 column", d, 40'h0202020202);
      chk("t1 erro", e, 0);
    end

    // wrap-around
    do_cmd(2'd0, 3'd2, 40'h7F80000000, 0, d, e);
    do_cmd(2'd1, 3'd2, 40'hFF01000000, 0, d, e);
    do_cmd(2'd2, 3'd0, '0, 0, d, e);
    do_cmd(2'd3, 3'd2, '0, 0, d, e);
    chk("wrap column", d, 40'h807F000000);

    // bad column load leaves A untouched
    do_cmd(2'd0, 3'd5, 40'hFFFFFFFFFF, 0, d, e);
    chk("bad column erro", e, 1);
    chk("bad column keeps valido", resultado_valido, 1);
    do_cmd(2'd2, 3'd0, '0, 0, d, e);
    do_cmd(2'd3, 3'd0, '0, 0, d, e);
    chk("A intact after bad load", d, 40'h0202020202);
    do_cmd(2'd3, 3'd7, '0, 0, d, e);
    chk("bad column read erro", e, 1);

    // back-pressure
    do_cmd(2'd3, 3'd1, '0, 4, d, e);
    chk("backpressure column", d, 40'h0202020202);

    // stale result
    do_cmd(2'd2, 3'd0, '0, 0, d, e);
    do_cmd(2'd1, 3'd0, 40'h0101010101, 0, d, e);
    do_cmd(2'd3, 3'd1, '0, 0, d, e);
    chk("stale read erro", e, 1);
    chk("stale read dados", d, 40'h0);
    chk("stale valido", resultado_valido, 0);
    do_cmd(2'd2, 3'd0, '0, 0, d, e);
    do_cmd(2'd3, 3'd0, '0, 0, d, e);
    chk("fresh read column", d, 40'h0404040404);
    chk("fresh read erro", e, 0);

    // reset while EXECUTANDO
    @(negedge clk);
    cmd_op = 2'd2; cmd_coluna = 3'd0; cmd_valid = 1'b1;
    chk("ready before reset exec", cmd_ready, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("executing no resp", resp_valid, 0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    expq.delete();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("no resp after reset", resp_valid, 0);
    end
    chk("valido after reset", resultado_valido, 0);
    chk("ready after reset", cmd_ready, 1);
    do_cmd(2'd2, 3'd0, '0, 0, d, e);
    do_cmd(2'd3, 3'd0, '0, 0, d, e);
    chk("cleared column 0", d, 40'h0);
    do_cmd(2'd3, 3'd2, '0, 0, d, e);
    chk("cleared column 2", d, 40'h0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
